// File: rtl/spi_cmd_master.sv
`default_nettype none
// spi_cmd_master: SPI mode-0 initiator serialising 10-bit {op,byte} commands, with byte read-back on rd-data.
// Optional feature macro SPI_MASTER_TXN_COUNT_EN builds the completed-frame counter on txn_count.
module spi_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int RD_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        done,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [15:0] txn_count
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST  = 4'((RD_GAP > 0) ? RD_GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, CMD, GAP, RD, STOP} state_t;

  state_t     state;
  logic [7:0] hcnt;
  logic [3:0] bcnt;
  logic [3:0] gcnt;
  logic [8:0] frame;     // bit 9 goes straight to MOSI, so only bits 8..0 are held
  logic       rd_frame;
  logic [7:0] rx;
  logic       half_end;

  assign half_end = (hcnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      SS_n      <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      done      <= 1'b0;
      hcnt      <= 8'd0;
      bcnt      <= 4'd0;
      gcnt      <= 4'd0;
      frame     <= 9'd0;
      rd_frame  <= 1'b0;
      rx        <= 8'h00;
`ifdef SPI_MASTER_TXN_COUNT_EN
      txn_count <= 16'h0000;
`endif
    end else begin
      done      <= 1'b0;
      rsp_valid <= 1'b0;
      if (state != IDLE) hcnt <= half_end ? HALF_LAST : hcnt - 8'd1;

      case (state)
        IDLE: begin
          if (req_valid) begin
            frame     <= {req_op[0], req_data};
            rd_frame  <= (req_op == 2'b11);
            MOSI      <= req_op[1];
            SS_n      <= 1'b0;
            req_ready <= 1'b0;
            hcnt      <= HALF_LAST;
            state     <= START;
          end
        end
        START: begin
          if (half_end) begin
            bcnt  <= 4'd0;
            state <= CMD;
          end
        end
        CMD: begin
          if (half_end) begin
            SCLK <= ~SCLK;
            if (SCLK) begin
              if (bcnt == 4'd9) begin
                MOSI <= 1'b0;
                bcnt <= 4'd0;
                gcnt <= 4'd0;
                if (!rd_frame)        state <= STOP;
                else if (RD_GAP == 0) state <= RD;
                else                  state <= GAP;
              end else begin
                bcnt  <= bcnt + 4'd1;
                MOSI  <= frame[8];
                frame <= {frame[7:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          if (half_end) begin
            SCLK <= ~SCLK;
            if (SCLK) begin
              if (gcnt == GAP_LAST) state <= RD;
              else                  gcnt  <= gcnt + 4'd1;
            end
          end
        end
        RD: begin
          if (half_end) begin
            SCLK <= ~SCLK;
            // sample on the clk edge that raises SCLK
            if (!SCLK)              rx    <= {rx[6:0], MISO};
            else if (bcnt == 4'd7)  state <= STOP;
            else                    bcnt  <= bcnt + 4'd1;
          end
        end
        STOP: begin
          if (half_end) begin
            SS_n      <= 1'b1;
            req_ready <= 1'b1;
            done      <= 1'b1;
            if (rd_frame) begin
              rsp_valid <= 1'b1;
              rsp_data  <= rx;
            end
`ifdef SPI_MASTER_TXN_COUNT_EN
            txn_count <= txn_count + 16'd1;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPI_MASTER_TXN_COUNT_EN
  assign txn_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_master.sv
`default_nettype none
// tb_spi_cmd_master: two instances (CLK_DIV=2/RD_GAP=2 and CLK_DIV=1/RD_GAP=0) checked every cycle
// against a frame-level waveform model, plus literal checks on measured frame lengths and data.
module tb_spi_cmd_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] miso = 2'b00;
  logic [1:0] req_ready, rsp_valid, done, ss_n, sclk, mosi;
  logic [1:0]  req_op   [2];
  logic [7:0]  req_data [2];
  logic [7:0]  rsp_data [2];
  logic [15:0] txn      [2];

  spi_cmd_master #(.CLK_DIV(2), .RD_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_data(req_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .done(done[0]), .SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]), .txn_count(txn[0]));

  spi_cmd_master #(.CLK_DIV(1), .RD_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_data(req_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .done(done[1]), .SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]), .txn_count(txn[1]));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int i, input logic [15:0] act_v, input logic [15:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, want %h (t=%0t)", name, i, act_v, exp_v, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int hdiv(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int hgap(input int i); return (i == 0) ? 2 : 0; endfunction
  function automatic int frame_len(input int i, input logic rd);
    return hdiv(i) * (2 + 2 * (10 + (rd ? hgap(i) + 8 : 0)));
  endfunction

  bit          act    [2] = '{0, 0};
  int          t      [2] = '{0, 0};
  int          flen   [2] = '{0, 0};
  int          hs_cnt [2] = '{0, 0};
  logic [9:0]  fr     [2];
  logic        rd     [2];
  logic [7:0]  mbyte  [2];
  logic [7:0]  lbyte  [2];
  logic [7:0]  m_rsp  [2];
  logic [15:0] m_cnt  [2];
  bit          rdy    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 0; t[i] = 0; m_cnt[i] = 16'h0; m_rsp[i] = 8'h0;
      end else begin
        rdy[i] = !act[i] || (t[i] == flen[i]);
        if (act[i] && t[i] == flen[i]) act[i] = 0;
        else if (act[i]) begin
          t[i]++;
          if (t[i] == flen[i]) begin
            m_cnt[i] = m_cnt[i] + 16'd1;
            if (rd[i]) m_rsp[i] = lbyte[i];
          end
        end
        if (req_valid[i] && rdy[i]) begin
          act[i]   = 1;
          t[i]     = 0;
          fr[i]    = {req_op[i], req_data[i]};
          rd[i]    = (req_op[i] == 2'b11);
          flen[i]  = frame_len(i, rd[i]);
          lbyte[i] = mbyte[i];
          hs_cnt[i]++;
        end
      end
    end
  end

  // ---------------- per-cycle compare, MISO slave, measurements ----------------
  logic       e_ss, e_sc, e_mo, e_rdy, e_done, e_rv, mbit;
  int         hi, p, ph, np;
  int         lowcnt   [2] = '{0, 0};
  int         last_len [2] = '{0, 0};
  logic [9:0] cap      [2] = '{10'd0, 10'd0};
  logic [9:0] last_cap [2] = '{10'd0, 10'd0};
  logic       psclk    [2] = '{1'b0, 1'b0};
  logic       pss      [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_ss = 1'b1; e_sc = 1'b0; e_mo = 1'b0; e_rdy = 1'b1; e_done = 1'b0; e_rv = 1'b0;
      mbit = 1'($urandom);
      if (act[i] && t[i] == flen[i]) begin
        e_done = 1'b1;
        e_rv   = rd[i];
      end else if (act[i]) begin
        e_ss = 1'b0; e_rdy = 1'b0;
        hi = t[i] / hdiv(i);
        if (hi == 0) e_mo = fr[i][9];
        else begin
          p  = (hi - 1) / 2;
          ph = (hi - 1) % 2;
          np = 10 + (rd[i] ? hgap(i) + 8 : 0);
          e_sc = (p < np) && (ph == 1);
          e_mo = (p < 10) ? fr[i][9 - p] : 1'b0;
          if (rd[i] && p >= 10 + hgap(i) && p < np) mbit = lbyte[i][7 - (p - 10 - hgap(i))];
        end
      end
      miso[i] = mbit;
      chk("SS_n", i, 16'(ss_n[i]), 16'(e_ss));
      chk("SCLK", i, 16'(sclk[i]), 16'(e_sc));
      chk("MOSI", i, 16'(mosi[i]), 16'(e_mo));
      chk("req_ready", i, 16'(req_ready[i]), 16'(e_rdy));
      chk("done", i, 16'(done[i]), 16'(e_done));
      chk("rsp_valid", i, 16'(rsp_valid[i]), 16'(e_rv));
      chk("rsp_data", i, 16'(rsp_data[i]), 16'(m_rsp[i]));
`ifdef SPI_MASTER_TXN_COUNT_EN
      chk("txn_count", i, txn[i], m_cnt[i]);
`else
      chk("txn_count", i, txn[i], 16'h0000);
`endif
      if (ss_n[i] == 1'b0) begin
        lowcnt[i]++;
        if (sclk[i] && !psclk[i]) cap[i] = {cap[i][8:0], mosi[i]};
      end else if (!pss[i]) begin
        last_len[i] = lowcnt[i];
        last_cap[i] = cap[i];
        lowcnt[i] = 0;
        cap[i] = 10'd0;
      end
      psclk[i] = sclk[i];
      pss[i]   = ss_n[i];
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int i, input logic [1:0] op, input logic [7:0] d, input logic [7:0] b, input bit keep);
    int start, n;
    @(negedge clk);
    req_valid[i] = 1'b1; req_op[i] = op; req_data[i] = d; mbyte[i] = b;
    start = hs_cnt[i]; n = 0;
    while (hs_cnt[i] == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL handshake dut%0d: none after %0d cycles, want one", i, n);
    end
    if (!keep) begin
      req_valid[i] = 1'b0;
      req_op[i]    = 2'($urandom);
      req_data[i]  = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (act[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL idle_wait dut%0d: still busy after %0d cycles, want idle", i, n);
    end
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = 2'b00; req_data[i] = 8'h00; mbyte[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send(0, 2'b00, 8'hA5, 8'h00, 0);
    wait_idle(0);
    chk("a5_ss_low_cycles", 0, 16'(last_len[0]), 16'd44);
    chk("a5_mosi_at_rise", 0, 16'(last_cap[0]), 16'(10'b0010100101));

    send(0, 2'b11, 8'h00, 8'h3C, 0);
    wait_idle(0);
    chk("rd_ss_low_cycles", 0, 16'(last_len[0]), 16'd84);
    chk("rd_rsp_data", 0, 16'(rsp_data[0]), 16'h003C);

    pulse_rst();
    send(0, 2'b00, 8'h12, 8'h00, 1);
    send(0, 2'b01, 8'h34, 8'h00, 1);
    send(0, 2'b10, 8'h56, 8'h00, 1);
    send(0, 2'b11, 8'h78, 8'hC3, 0);
    wait_idle(0);
`ifdef SPI_MASTER_TXN_COUNT_EN
    chk("b2b_txn_count", 0, txn[0], 16'd4);
`else
    chk("b2b_txn_count", 0, txn[0], 16'd0);
`endif
    chk("b2b_rsp_data", 0, 16'(rsp_data[0]), 16'h00C3);

    // abort during command bit 5
    pulse_rst();
    send(0, 2'b01, 8'h9E, 8'h00, 0);
    n = 0;
    while (t[0] < 2 * (1 + 2 * 5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ss_n", 0, 16'(ss_n[0]), 16'd1);
    chk("abort_sclk", 0, 16'(sclk[0]), 16'd0);
    chk("abort_ready", 0, 16'(req_ready[0]), 16'd1);
    chk("abort_txn", 0, txn[0], 16'd0);
    repeat (30) @(negedge clk);

    send(1, 2'b11, 8'h5A, 8'hFF, 0);
    wait_idle(1);
    chk("fast_ss_low_cycles", 1, 16'(last_len[1]), 16'd38);
    chk("fast_rsp_data", 1, 16'(rsp_data[1]), 16'h00FF);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) begin
        send(i, 2'($urandom), 8'($urandom), 8'($urandom), (k < 15) && ($urandom_range(0, 1) == 1));
        if (!req_valid[i]) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(i);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
